// File: rtl/wdg_multi_top.sv
// Multi-channel two-stage watchdog with a pipelined Wishbone slave port.
// Each channel raises a stage-1 warning, then a stage-2 fault, unless kicked with key 0xA5.
module wdg_multi_top #(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned CNT_W         = 10,
  parameter int unsigned ADDR_W        = 4,
  parameter int unsigned EXT_TICK      = 0,
  parameter int unsigned TICK_BIT      = 2,
  parameter int unsigned WB_DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     i_tick,
  input  logic                     i_wb_cyc,
  input  logic                     i_wb_stb,
  input  logic                     i_wb_we,
  input  logic [ADDR_W-1:0]        i_wb_adr,
  input  logic [WB_DATA_WIDTH-1:0] i_wb_dat,
  input  logic [3:0]               i_wb_sel,
  output logic                     o_wb_stall,
  output logic                     o_wb_ack,
  output logic                     o_wb_err,
  output logic                     o_wb_rty,
  output logic [WB_DATA_WIDTH-1:0] o_wb_dat,
  output logic [NUM_CH-1:0]        o_irq1,
  output logic [NUM_CH-1:0]        o_irq2
);

  localparam int unsigned CH_W = ADDR_W - 3;

  typedef enum logic [1:0] {StDis, St1, St2} state_e;

  logic                     w_tick;
  logic                     w_acc;
  logic [CH_W-1:0]          w_ch;
  logic                     w_ch_ok;
  logic [WB_DATA_WIDTH-1:0] w_rd;
  logic [WB_DATA_WIDTH-1:0] w_csr_rd [NUM_CH];
  logic [WB_DATA_WIDTH-1:0] w_cnt_rd [NUM_CH];
  logic [NUM_CH-1:0]        w_irq1;
  logic [NUM_CH-1:0]        w_irq2;
  logic                     w_unused;

  logic                     r_ack;
  logic                     r_err;
  logic [WB_DATA_WIDTH-1:0] r_dat;

  assign w_acc   = i_wb_cyc & i_wb_stb;
  assign w_ch    = i_wb_adr[ADDR_W-1:3];
  assign w_ch_ok = (32'(w_ch) < NUM_CH);
  assign w_unused = ^{i_wb_adr[1:0], i_tick};

  // Shared tick source for every channel.
  if (EXT_TICK != 0) begin : gen_ext_tick
    assign w_tick = i_tick;
  end else if (TICK_BIT == 0) begin : gen_clk_tick
    assign w_tick = 1'b1;
  end else begin : gen_pre_tick
    logic [TICK_BIT-1:0] r_pre;
    always_ff @(posedge clk) begin
      if (res) begin
        r_pre <= '0;
      end else begin
        r_pre <= r_pre + TICK_BIT'(1);
      end
    end
    assign w_tick = &r_pre;
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
    state_e                   r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         r_wto;
    logic                     r_win;
    logic                     r_irq1;
    logic                     r_irq2;
    logic                     w_hit;
    logic                     w_csr_wr;
    logic                     w_kick;
    logic                     w_fault;
    logic [CNT_W-1:0]         w_lim;
    logic [WB_DATA_WIDTH-1:0] w_csr;
    logic [WB_DATA_WIDTH-1:0] w_csr_new;

    assign w_hit    = w_acc & w_ch_ok & (w_ch == CH_W'(gi));
    assign w_csr_wr = w_hit & i_wb_we & ~i_wb_adr[2];
    assign w_kick   = w_hit & i_wb_we & i_wb_adr[2] & i_wb_sel[0] & (i_wb_dat[7:0] == 8'hA5);
    assign w_fault  = (r_state == St1) & r_win & (r_cnt < (r_wto >> 1));

    assign w_csr = {{(WB_DATA_WIDTH-4-CNT_W){1'b0}}, r_wto, r_irq2, r_irq1, r_win,
                    (r_state != StDis)};

    always_comb begin
      w_csr_new = w_csr;
      for (int b = 0; b < 4; b++) begin
        if (i_wb_sel[b]) begin
          w_csr_new[8*b +: 8] = i_wb_dat[8*b +: 8];
        end
      end
    end

    // A new WTOCNT written this cycle already governs a coincident tick.
    assign w_lim = w_csr_wr ? w_csr_new[CNT_W+3:4] : r_wto;

    always_ff @(posedge clk) begin
      if (res) begin
        r_state <= StDis;
        r_cnt   <= '0;
        r_wto   <= '0;
        r_win   <= 1'b0;
        r_irq1  <= 1'b0;
        r_irq2  <= 1'b0;
      end else begin
        if (w_csr_wr) begin
          r_win <= w_csr_new[1];
          r_wto <= w_csr_new[CNT_W+3:4];
        end
        if (w_csr_wr && !w_csr_new[0]) begin
          r_state <= StDis;
          r_cnt   <= '0;
          r_irq1  <= 1'b0;
          r_irq2  <= 1'b0;
        end else if (w_csr_wr && (r_state == StDis)) begin
          r_state <= St1;
          r_cnt   <= '0;
        end else if (w_kick && (r_state != StDis)) begin
          r_state <= St1;
          r_cnt   <= '0;
          r_irq1  <= 1'b0;
          if (w_fault) begin
            r_irq2 <= 1'b1;
          end
        end else if (w_tick) begin
          unique case (r_state)
            StDis: r_cnt <= '0;
            St1: begin
              if (r_cnt >= w_lim) begin
                r_cnt   <= '0;
                r_irq1  <= 1'b1;
                r_state <= St2;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
            St2: begin
              if (r_cnt >= w_lim) begin
                r_irq2 <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
            default: r_state <= StDis;
          endcase
        end
      end
    end

    assign w_csr_rd[gi] = w_csr;
    assign w_cnt_rd[gi] = {(r_state == St2), {(WB_DATA_WIDTH-1-CNT_W){1'b0}}, r_cnt};
    assign w_irq1[gi]   = r_irq1;
    assign w_irq2[gi]   = r_irq2;
  end

  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ch == CH_W'(i)) begin
        w_rd = i_wb_adr[2] ? w_cnt_rd[i] : w_csr_rd[i];
      end
    end
  end

  // Read data is captured before the same request's write lands.
  always_ff @(posedge clk) begin
    if (res) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_acc & w_ch_ok;
      r_err <= w_acc & ~w_ch_ok;
      if (w_acc) begin
        r_dat <= w_ch_ok ? w_rd : '0;
      end
    end
  end

  assign o_wb_stall = 1'b0;
  assign o_wb_rty   = 1'b0;
  assign o_wb_ack   = r_ack;
  assign o_wb_err   = r_err;
  assign o_wb_dat   = r_dat;
  assign o_irq1     = w_irq1;
  assign o_irq2     = w_irq2;

endmodule

// File: tb/tb_wdg_multi_top.sv
// Directed bench for wdg_multi_top: one instance on the internal prescaler tick,
// one on the external tick, both with NUM_CH=2 and ADDR_W=5.
module tb_wdg_multi_top;

  logic        clk = 1'b0;
  logic        res;
  logic        tick;
  logic        cyc_int, cyc_ext, stb, we;
  logic [4:0]  adr;
  logic [31:0] wdat;
  logic [3:0]  sel;

  logic        stall_int, ack_int, err_int, rty_int;
  logic [31:0] dat_int;
  logic [1:0]  irq1_int, irq2_int;
  logic        stall_ext, ack_ext, err_ext, rty_ext;
  logic [31:0] dat_ext;
  logic [1:0]  irq1_ext, irq2_ext;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wdg_multi_top #(
    .NUM_CH(2), .CNT_W(10), .ADDR_W(5), .EXT_TICK(0), .TICK_BIT(2), .WB_DATA_WIDTH(32)
  ) u_dut_int (
    .clk(clk), .res(res), .i_tick(tick),
    .i_wb_cyc(cyc_int), .i_wb_stb(stb), .i_wb_we(we), .i_wb_adr(adr),
    .i_wb_dat(wdat), .i_wb_sel(sel),
    .o_wb_stall(stall_int), .o_wb_ack(ack_int), .o_wb_err(err_int), .o_wb_rty(rty_int),
    .o_wb_dat(dat_int), .o_irq1(irq1_int), .o_irq2(irq2_int)
  );

  wdg_multi_top #(
    .NUM_CH(2), .CNT_W(10), .ADDR_W(5), .EXT_TICK(1), .TICK_BIT(2), .WB_DATA_WIDTH(32)
  ) u_dut_ext (
    .clk(clk), .res(res), .i_tick(tick),
    .i_wb_cyc(cyc_ext), .i_wb_stb(stb), .i_wb_we(we), .i_wb_adr(adr),
    .i_wb_dat(wdat), .i_wb_sel(sel),
    .o_wb_stall(stall_ext), .o_wb_ack(ack_ext), .o_wb_err(err_ext), .o_wb_rty(rty_ext),
    .o_wb_dat(dat_ext), .o_irq1(irq1_ext), .o_irq2(irq2_ext)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request; returns at the ack cycle (one clock after acceptance).
  task automatic wb_xfer(input bit ext, input bit w, input logic [4:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output logic ack,
                         output logic err);
    cyc_int = !ext;
    cyc_ext = ext;
    stb = 1'b1;
    we = w;
    adr = a;
    wdat = d;
    sel = s;
    @(posedge clk); #1;
    cyc_int = 1'b0;
    cyc_ext = 1'b0;
    stb = 1'b0;
    we = 1'b0;
    rd  = ext ? dat_ext : dat_int;
    ack = ext ? ack_ext : ack_int;
    err = ext ? err_ext : err_int;
  endtask

  task automatic wr(input bit ext, input logic [4:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic ack, err;
    wb_xfer(ext, 1'b1, a, d, 4'hF, rd, ack, err);
  endtask

  task automatic rdreg(input bit ext, input logic [4:0] a, output logic [31:0] rd);
    logic ack, err;
    wb_xfer(ext, 1'b0, a, 32'h0, 4'hF, rd, ack, err);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  function automatic logic irq_bit(input bit ext, input bit s2, input int ch);
    logic [1:0] v;
    v = ext ? (s2 ? irq2_ext : irq1_ext) : (s2 ? irq2_int : irq1_int);
    return v[ch];
  endfunction

  task automatic wait_irq(input bit ext, input bit s2, input int ch, input int max,
                          output int n);
    n = 0;
    while (!irq_bit(ext, s2, ch) && n < max) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic poll_cnt(input logic [4:0] a, input logic [9:0] target, input int max,
                          output bit ok);
    logic [31:0] rd;
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      rdreg(1'b0, a, rd);
      if (rd[9:0] == target) ok = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic ack, err;
    int n;
    bit seen, ok;

    res = 1'b1; tick = 1'b0; cyc_int = 1'b0; cyc_ext = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; wdat = '0; sel = '0;
    repeat (2) @(posedge clk);
    #1;
    res = 1'b0;

    check("rst_bus_int", 32'({stall_int, ack_int, err_int, rty_int}), 32'h0);
    check("rst_dat_int", dat_int, 32'h0);
    check("rst_irq_int", 32'({irq1_int, irq2_int}), 32'h0);

    // Stage-1 / stage-2 timeout on the internal prescaler, WTOCNT=16 -> 68 clk per stage.
    wb_xfer(1'b0, 1'b1, 5'h00, 32'h101, 4'hF, rd, ack, err);
    check("wr_ack", 32'({err, ack}), 32'h1);
    wait_irq(1'b0, 1'b0, 0, 100, n);
    check("irq1_delay", (n >= 64 && n <= 72) ? 32'd68 : 32'(n), 32'd68);
    check("irq2_still_low", 32'(irq2_int[0]), 32'h0);
    wait_irq(1'b0, 1'b1, 0, 100, n);
    check("irq2_delay", (n >= 64 && n <= 72) ? 32'd68 : 32'(n), 32'd68);
    rdreg(1'b0, 5'h00, rd);
    check("csr_st2", rd, 32'h10D);
    rdreg(1'b0, 5'h04, rd);
    check("cnt_st2", rd, 32'h8000_0010);
    wb_xfer(1'b0, 1'b1, 5'h00, 32'h100, 4'hF, rd, ack, err);
    check("wr_dat_before", rd, 32'h10D);
    check("dis_clears_irq", 32'({irq1_int[0], irq2_int[0]}), 32'h0);

    // Keyed kick every 40 clk keeps both stages quiet for 1000 clk.
    wr(1'b0, 5'h00, 32'h101);
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      wr(1'b0, 5'h04, 32'hA5);
      repeat (39) begin
        @(posedge clk); #1;
        if (irq1_int[0] | irq2_int[0]) seen = 1'b1;
      end
    end
    check("kick_quiet", 32'(seen), 32'h0);
    wr(1'b0, 5'h04, 32'h5A);
    wait_irq(1'b0, 1'b0, 0, 100, n);
    check("bad_key_irq1", (n + 40 >= 64 && n + 40 <= 72) ? 32'd68 : 32'(n + 40), 32'd68);
    wr(1'b0, 5'h00, 32'h100);

    // Window fault on ch1: early kick faults, late kick does not.
    wr(1'b0, 5'h08, 32'h103);
    poll_cnt(5'h0C, 10'd3, 200, ok);
    check("poll3", 32'(ok), 32'h1);
    wr(1'b0, 5'h0C, 32'hA5);
    check("win_early_irq2", 32'(irq2_int[1]), 32'h1);
    check("win_early_irq1", 32'(irq1_int[1]), 32'h0);
    wr(1'b0, 5'h08, 32'h102);
    check("win_dis_clear", 32'(irq2_int[1]), 32'h0);
    wr(1'b0, 5'h08, 32'h103);
    poll_cnt(5'h0C, 10'd9, 200, ok);
    check("poll9", 32'(ok), 32'h1);
    wr(1'b0, 5'h0C, 32'hA5);
    check("win_late_irq2", 32'(irq2_int[1]), 32'h0);

    // External tick: WTOCNT=5, seven ticks -> stage 2 with count 1.
    wr(1'b1, 5'h00, 32'h51);
    repeat (7) begin
      pulse_tick();
      @(posedge clk); #1;
    end
    rdreg(1'b1, 5'h04, rd);
    check("ext_cnt", rd, 32'h8000_0001);
    check("ext_irq", 32'({irq2_ext[0], irq1_ext[0]}), 32'h1);
    rdreg(1'b1, 5'h00, rd);
    check("ext_csr", rd, 32'h55);

    // Kick and tick in the same cycle: kick wins.
    tick = 1'b1;
    wr(1'b1, 5'h04, 32'hA5);
    tick = 1'b0;
    rdreg(1'b1, 5'h04, rd);
    check("kick_tick_cnt", rd, 32'h0);
    check("kick_clears_irq1", 32'(irq1_ext[0]), 32'h0);

    // Byte selects, and status bits are not writable.
    wb_xfer(1'b1, 1'b1, 5'h00, 32'h0000_0300, 4'b0010, rd, ack, err);
    rdreg(1'b1, 5'h00, rd);
    check("sel_byte1", rd, 32'h351);
    wb_xfer(1'b1, 1'b1, 5'h00, 32'hFFFF_FF0D, 4'b0001, rd, ack, err);
    rdreg(1'b1, 5'h00, rd);
    check("sel_byte0_ro", rd, 32'h301);

    // Unmapped channel: err for one cycle, no ack, no state change.
    wb_xfer(1'b1, 1'b1, 5'h10, 32'h0, 4'hF, rd, ack, err);
    check("err_wr", 32'({err, ack}), 32'h2);
    @(posedge clk); #1;
    check("err_one_cycle", 32'({err_ext, ack_ext}), 32'h0);
    wb_xfer(1'b1, 1'b0, 5'h18, 32'h0, 4'hF, rd, ack, err);
    check("err_rd", 32'({err, ack}), 32'h2);
    check("err_rd_dat", rd, 32'h0);
    rdreg(1'b1, 5'h00, rd);
    check("err_no_effect", rd, 32'h301);

    // WTOCNT=0 on ch1: each tick advances a stage; then reset in stage 2.
    wr(1'b1, 5'h08, 32'h01);
    pulse_tick();
    check("wto0_st1", 32'({irq2_ext[1], irq1_ext[1]}), 32'h1);
    pulse_tick();
    check("wto0_st2", 32'({irq2_ext[1], irq1_ext[1]}), 32'h3);
    rdreg(1'b1, 5'h08, rd);
    check("wto0_csr", rd, 32'h0D);
    res = 1'b1;
    cyc_ext = 1'b1; stb = 1'b1; we = 1'b0; adr = 5'h08; sel = 4'hF;
    @(posedge clk); #1;
    res = 1'b0;
    cyc_ext = 1'b0; stb = 1'b0;
    check("rst_no_ack", 32'({ack_ext, err_ext}), 32'h0);
    check("rst_dat", dat_ext, 32'h0);
    check("rst_irq", 32'({irq1_ext, irq2_ext}), 32'h0);
    rdreg(1'b1, 5'h08, rd);
    check("rst_csr", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
